l2_pri_bank_arbiter: RTL and testbench

Round-robin arbiter placed directly upstream of one L2 private-bank slave port. It merges NB_MASTERS TCDM-style master ports onto the single bank port. Each bank response is routed back to the master that issued the request. An internal ID FIFO lets the block tolerate response latency above one cycle, even though the L2 banks answer with a fixed one-cycle r_valid.

---
 rtl/l2_arb_pkg.sv | 31 +++
 rtl/l2_arb_id_fifo.sv | 62 ++++++
 rtl/l2_pri_bank_arbiter.sv | 123 ++++++++++++
 tb/tb_l2_pri_bank_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_arb_pkg.sv
// Shared types and the round-robin search helper for the L2 private-bank arbiter.
// The helper works on a fixed-width request vector so any master count up to MAX_MASTERS fits.
package l2_arb_pkg;

  localparam int unsigned MAX_MASTERS = 32;
  localparam int unsigned IDX_W       = 5;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // First requester at or above ptr, wrapping modulo n; only the low n bits of req are looked at.
  function automatic rr_pick_t rr_pick(input logic [MAX_MASTERS-1:0] req,
                                       input logic [IDX_W-1:0]       ptr,
                                       input int unsigned            n);
    rr_pick_t    res;
    int unsigned pos;
    res = '0;
    for (int unsigned k = 0; k < MAX_MASTERS; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= n) pos = pos - n;
      if ((k < n) && !res.found && req[pos[IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = pos[IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/l2_arb_id_fifo.sv
// Small FIFO of master indices, one entry per granted request still waiting for its response.
// Head is read combinationally so a response can be routed in the cycle it arrives.
module l2_arb_id_fifo
  import l2_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push_i) wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
    if (pop_i)  rd_ptr_next = (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
    case ({push_i, pop_i})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Payload needs no reset: count gates every read of it.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_reg[wr_ptr_reg] <= data_i;
  end

  assign head_o  = mem_reg[rd_ptr_reg];
  assign count_o = count_reg;
  assign full_o  = (count_reg == CNT_W'(DEPTH));
  assign empty_o = (count_reg == '0);

endmodule

// File: rtl/l2_pri_bank_arbiter.sv
// Round-robin merge of NB_MASTERS TCDM ports onto one L2 private-bank port; responses are
// routed back to the issuing master through an ID FIFO so bank latency above one cycle is tolerated.
module l2_pri_bank_arbiter
  import l2_arb_pkg::*;
#(
  parameter int unsigned NB_MASTERS = 3,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RESP_DEPTH = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NB_MASTERS-1:0]            m_req_i,
  input  logic [NB_MASTERS*ADDR_WIDTH-1:0] m_add_i,
  input  logic [NB_MASTERS-1:0]            m_wen_i,
  input  logic [NB_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
  input  logic [NB_MASTERS*DATA_WIDTH/8-1:0] m_be_i,
  output logic [NB_MASTERS-1:0]            m_gnt_o,
  output logic [NB_MASTERS-1:0]            m_r_valid_o,
  output logic [DATA_WIDTH-1:0]            m_r_rdata_o,
  output logic                             m_r_opc_o,
  output logic                             s_req_o,
  output logic [ADDR_WIDTH-1:0]            s_add_o,
  output logic                             s_wen_o,
  output logic [DATA_WIDTH-1:0]            s_wdata_o,
  output logic [DATA_WIDTH/8-1:0]          s_be_o,
  input  logic                             s_gnt_i,
  input  logic                             s_r_valid_i,
  input  logic [DATA_WIDTH-1:0]            s_r_rdata_i,
  input  logic                             s_r_opc_i,
  output logic                             err_o
);

  localparam int unsigned RR_W  = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;
  localparam int unsigned CNT_W = $clog2(RESP_DEPTH) + 1;
  localparam int unsigned BE_W  = DATA_WIDTH / 8;

  logic [RR_W-1:0]        rr_reg, rr_next;
  logic                   err_reg, err_next;
  logic [MAX_MASTERS-1:0] req_ext;
  rr_pick_t               pick;
  logic [NB_MASTERS-1:0]  sel;
  logic [RR_W-1:0]        win_idx;
  logic                   can_issue;
  logic                   grant;
  logic                   pop;
  logic [RR_W-1:0]        fifo_head;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;

  always_comb begin
    req_ext                 = '0;
    req_ext[NB_MASTERS-1:0] = m_req_i;
    pick                    = rr_pick(req_ext, IDX_W'(rr_reg), NB_MASTERS);
  end

  for (genvar gi = 0; gi < NB_MASTERS; gi++) begin : g_master
    assign sel[gi]         = pick.found && (pick.idx == IDX_W'(gi));
    assign m_gnt_o[gi]     = sel[gi] & grant;
    assign m_r_valid_o[gi] = pop && (fifo_head == RR_W'(gi));
  end

  // sel is one-hot or zero, so OR-ing the selected payloads is a plain mux with zero default.
  always_comb begin
    s_add_o   = '0;
    s_wen_o   = 1'b0;
    s_wdata_o = '0;
    s_be_o    = '0;
    win_idx   = '0;
    for (int i = 0; i < NB_MASTERS; i++) begin
      if (sel[i]) begin
        s_add_o   = s_add_o   | m_add_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        s_wen_o   = s_wen_o   | m_wen_i[i];
        s_wdata_o = s_wdata_o | m_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        s_be_o    = s_be_o    | m_be_i[i*BE_W +: BE_W];
        win_idx   = win_idx   | RR_W'(i);
      end
    end
  end

  // A response in this cycle frees a slot, so a full FIFO can still accept the next grant.
  assign can_issue = (fifo_count < CNT_W'(RESP_DEPTH)) || s_r_valid_i;
  assign s_req_o   = (|m_req_i) && can_issue;
  assign grant     = s_req_o && s_gnt_i;
  assign pop       = s_r_valid_i && !fifo_empty;

  always_comb begin
    rr_next  = rr_reg;
    err_next = err_reg | (s_r_valid_i & fifo_empty);
    if (grant) rr_next = (win_idx == RR_W'(NB_MASTERS - 1)) ? '0 : win_idx + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_reg  <= '0;
      err_reg <= 1'b0;
    end else begin
      rr_reg  <= rr_next;
      err_reg <= err_next;
    end
  end

  l2_arb_id_fifo #(
    .WIDTH (RR_W),
    .DEPTH (RESP_DEPTH)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (grant && (!fifo_full || pop)),
    .data_i  (win_idx),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign m_r_rdata_o = s_r_rdata_i;
  assign m_r_opc_o   = s_r_opc_i;
  assign err_o       = err_reg;

endmodule

// File: tb/tb_l2_pri_bank_arbiter.sv
// Directed bench for l2_pri_bank_arbiter: 3 masters, response depth 2, bank driven by hand.
module tb_l2_pri_bank_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [2:0]  m_req_i;
  logic [31:0] add_a   [3];
  logic [2:0]  m_wen_i;
  logic [31:0] wdata_a [3];
  logic [3:0]  be_a    [3];
  logic [95:0] m_add_i;
  logic [95:0] m_wdata_i;
  logic [11:0] m_be_i;
  logic [2:0]  m_gnt_o;
  logic [2:0]  m_r_valid_o;
  logic [31:0] m_r_rdata_o;
  logic        m_r_opc_o;
  logic        s_req_o;
  logic [31:0] s_add_o;
  logic        s_wen_o;
  logic [31:0] s_wdata_o;
  logic [3:0]  s_be_o;
  logic        s_gnt_i;
  logic        s_r_valid_i;
  logic [31:0] s_r_rdata_i;
  logic        s_r_opc_i;
  logic        err_o;

  int errors = 0;
  int checks = 0;

  assign m_add_i   = {add_a[2], add_a[1], add_a[0]};
  assign m_wdata_i = {wdata_a[2], wdata_a[1], wdata_a[0]};
  assign m_be_i    = {be_a[2], be_a[1], be_a[0]};

  always #5 clk_i = ~clk_i;

  l2_pri_bank_arbiter #(
    .NB_MASTERS (3),
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .RESP_DEPTH (2)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .m_req_i     (m_req_i),
    .m_add_i     (m_add_i),
    .m_wen_i     (m_wen_i),
    .m_wdata_i   (m_wdata_i),
    .m_be_i      (m_be_i),
    .m_gnt_o     (m_gnt_o),
    .m_r_valid_o (m_r_valid_o),
    .m_r_rdata_o (m_r_rdata_o),
    .m_r_opc_o   (m_r_opc_o),
    .s_req_o     (s_req_o),
    .s_add_o     (s_add_o),
    .s_wen_o     (s_wen_o),
    .s_wdata_o   (s_wdata_o),
    .s_be_o      (s_be_o),
    .s_gnt_i     (s_gnt_i),
    .s_r_valid_i (s_r_valid_i),
    .s_r_rdata_i (s_r_rdata_i),
    .s_r_opc_i   (s_r_opc_i),
    .err_o       (err_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_reset();
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; m_req_i = '0; m_wen_i = '0; s_gnt_i = 1'b0;
    s_r_valid_i = 1'b0; s_r_rdata_i = '0; s_r_opc_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      add_a[i] = 32'h1000_0000 + 32'(i * 4); wdata_a[i] = '0; be_a[i] = 4'hF;
    end
    @(negedge clk_i);
    checks++; if (m_gnt_o !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b want 000", m_gnt_o); end
    checks++; if (m_r_valid_o !== 3'b000) begin errors++; $display("FAIL reset_rvalid: got %b want 000", m_r_valid_o); end
    checks++; if (s_req_o !== 1'b0) begin errors++; $display("FAIL reset_sreq: got %b want 0", s_req_o); end
    checks++; if (s_add_o !== 32'h0) begin errors++; $display("FAIL reset_sadd: got %h want 0", s_add_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_o); end
    tick();
    rst_ni = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_single_read();
    add_a[1] = 32'h1C01_0004; m_wen_i = 3'b010; m_req_i = 3'b010; s_gnt_i = 1'b1;
    @(negedge clk_i);
    checks++; if (m_gnt_o !== 3'b010) begin errors++; $display("FAIL single_gnt: got %b want 010", m_gnt_o); end
    checks++; if (s_req_o !== 1'b1) begin errors++; $display("FAIL single_sreq: got %b want 1", s_req_o); end
    checks++; if (s_add_o !== 32'h1C01_0004) begin errors++; $display("FAIL single_sadd: got %h want 1c010004", s_add_o); end
    checks++; if (s_wen_o !== 1'b1) begin errors++; $display("FAIL single_swen: got %b want 1", s_wen_o); end
    tick();
    m_req_i = '0; s_r_valid_i = 1'b1; s_r_rdata_i = 32'hA5A5_0001; s_r_opc_i = 1'b1;
    @(negedge clk_i);
    checks++; if (m_r_valid_o !== 3'b010) begin errors++; $display("FAIL single_rvalid: got %b want 010", m_r_valid_o); end
    checks++; if (m_r_rdata_o !== 32'hA5A5_0001) begin errors++; $display("FAIL single_rdata: got %h want a5a50001", m_r_rdata_o); end
    checks++; if (m_r_opc_o !== 1'b1) begin errors++; $display("FAIL single_opc: got %b want 1", m_r_opc_o); end
    checks++; if (m_gnt_o !== 3'b000) begin errors++; $display("FAIL single_nognt: got %b want 000", m_gnt_o); end
    tick();
    s_r_valid_i = 1'b0; s_r_opc_i = 1'b0; m_wen_i = '0;
    $display("test_single_read done");
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g, exp_v;
    pulse_reset();
    for (int i = 0; i < 3; i++) add_a[i] = 32'h0000_0100 + 32'(i * 4);
    s_gnt_i = 1'b1;
    for (int c = 0; c < 7; c++) begin
      m_req_i     = (c < 6) ? 3'b111 : 3'b000;
      s_r_valid_i = (c > 0);
      exp_g = (c < 6) ? 3'(1 << (c % 3)) : 3'b000;
      exp_v = (c > 0) ? 3'(1 << ((c - 1) % 3)) : 3'b000;
      @(negedge clk_i);
      checks++; if (m_gnt_o !== exp_g) begin errors++; $display("FAIL rr_gnt c%0d: got %b want %b", c, m_gnt_o, exp_g); end
      checks++; if (m_r_valid_o !== exp_v) begin errors++; $display("FAIL rr_rvalid c%0d: got %b want %b", c, m_r_valid_o, exp_v); end
      if (c < 6) begin
        checks++;
        if (s_add_o !== 32'h100 + 32'((c % 3) * 4)) begin
          errors++; $display("FAIL rr_sadd c%0d: got %h want %h", c, s_add_o, 32'h100 + 32'((c % 3) * 4));
        end
      end
      tick();
    end
    s_r_valid_i = 1'b0;
    $display("test_round_robin done");
  endtask

  task automatic test_gnt_stall();
    // rr is back at 0 here; master 2 writes while the bank withholds its grant.
    m_req_i = 3'b100; m_wen_i = 3'b000; wdata_a[2] = 32'hDEAD_BEEF; be_a[2] = 4'b0110;
    s_gnt_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      checks++; if (m_gnt_o !== 3'b000) begin errors++; $display("FAIL stall_gnt c%0d: got %b want 000", c, m_gnt_o); end
      checks++; if (s_req_o !== 1'b1) begin errors++; $display("FAIL stall_sreq c%0d: got %b want 1", c, s_req_o); end
      tick();
    end
    s_gnt_i = 1'b1;
    @(negedge clk_i);
    checks++; if (m_gnt_o !== 3'b100) begin errors++; $display("FAIL stall_gnt_rise: got %b want 100", m_gnt_o); end
    checks++; if (s_wdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stall_wdata: got %h want deadbeef", s_wdata_o); end
    checks++; if (s_be_o !== 4'b0110) begin errors++; $display("FAIL stall_be: got %b want 0110", s_be_o); end
    checks++; if (s_wen_o !== 1'b0) begin errors++; $display("FAIL stall_wen: got %b want 0", s_wen_o); end
    tick();
    // rr now 0: master 0 wins over master 1 while master 2's response returns.
    m_req_i = 3'b011; s_r_valid_i = 1'b1;
    @(negedge clk_i);
    checks++; if (m_r_valid_o !== 3'b100) begin errors++; $display("FAIL stall_rvalid: got %b want 100", m_r_valid_o); end
    checks++; if (m_gnt_o !== 3'b001) begin errors++; $display("FAIL stall_next_gnt: got %b want 001", m_gnt_o); end
    tick();
    m_req_i = 3'b000;
    @(negedge clk_i);
    checks++; if (m_r_valid_o !== 3'b001) begin errors++; $display("FAIL stall_rvalid2: got %b want 001", m_r_valid_o); end
    tick();
    s_r_valid_i = 1'b0;
    $display("test_gnt_stall done");
  endtask

  task automatic test_latency3();
    logic [2:0] req_v  [7] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b000, 3'b000, 3'b000};
    logic       rv_v   [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [2:0] gnt_v  [7] = '{3'b001, 3'b010, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000};
    logic       sreq_v [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [2:0] val_v  [7] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b010, 3'b000, 3'b100};
    s_gnt_i = 1'b1;
    for (int c = 0; c < 7; c++) begin
      m_req_i = req_v[c]; s_r_valid_i = rv_v[c];
      @(negedge clk_i);
      checks++; if (m_gnt_o !== gnt_v[c]) begin errors++; $display("FAIL lat3_gnt c%0d: got %b want %b", c, m_gnt_o, gnt_v[c]); end
      checks++; if (s_req_o !== sreq_v[c]) begin errors++; $display("FAIL lat3_sreq c%0d: got %b want %b", c, s_req_o, sreq_v[c]); end
      checks++; if (m_r_valid_o !== val_v[c]) begin errors++; $display("FAIL lat3_rvalid c%0d: got %b want %b", c, m_r_valid_o, val_v[c]); end
      tick();
    end
    s_r_valid_i = 1'b0;
    $display("test_latency3 done");
  endtask

  task automatic test_error();
    m_req_i = '0; s_r_valid_i = 1'b1;
    @(negedge clk_i);
    checks++; if (m_r_valid_o !== 3'b000) begin errors++; $display("FAIL err_rvalid: got %b want 000", m_r_valid_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_same_cycle: got %b want 0", err_o); end
    tick();
    s_r_valid_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky c%0d: got %b want 1", c, err_o); end
      tick();
    end
    $display("test_error done");
  endtask

  task automatic test_reset_mid();
    // Grant masters 0 then 1 with no responses: two outstanding, rr left at 2.
    s_gnt_i = 1'b1;
    m_req_i = 3'b001;
    tick();
    m_req_i = 3'b010;
    tick();
    m_req_i = 3'b000;
    rst_ni  = 1'b0;
    #1;
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rstmid_err: got %b want 0", err_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    // rr back at 0 picks master 0 out of {0,2}; a stale rr of 2 would pick master 2.
    m_req_i = 3'b101;
    @(negedge clk_i);
    checks++; if (m_gnt_o !== 3'b001) begin errors++; $display("FAIL rstmid_gnt0: got %b want 001", m_gnt_o); end
    tick();
    // Only one entry outstanding now, so master 2 must not stall.
    m_req_i = 3'b100;
    @(negedge clk_i);
    checks++; if (m_gnt_o !== 3'b100) begin errors++; $display("FAIL rstmid_gnt2: got %b want 100", m_gnt_o); end
    tick();
    m_req_i = 3'b000; s_r_valid_i = 1'b1;
    @(negedge clk_i);
    checks++; if (m_r_valid_o !== 3'b001) begin errors++; $display("FAIL rstmid_rv0: got %b want 001", m_r_valid_o); end
    tick();
    @(negedge clk_i);
    checks++; if (m_r_valid_o !== 3'b100) begin errors++; $display("FAIL rstmid_rv2: got %b want 100", m_r_valid_o); end
    tick();
    s_r_valid_i = 1'b0;
    @(negedge clk_i);
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rstmid_noerr: got %b want 0", err_o); end
    tick();
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_gnt_stall();
    test_latency3();
    test_error();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
